shift_exec_unit: RTL and testbench
==================================

Name: shift_exec_unit

Overview:
- Execute-stage shift unit for the core.
- Accepts decoded shift micro-ops (SLL/SRL/SRA, plus RV64 *W variants) over a valid/ready handshake and prepares operands.
- Drives the combinational full_barrel_shifter and delivers the sign-corrected result downstream through a 2-stage elastic pipeline.
- Sits between decode/issue and the writeback mux.

Parameters:
- XLEN, 64: datapath width (32 or 64).
- TAG_W, 5: width of the opaque tag (rd index) carried alongside each op.

Ports:
- clock, input, 1: system clock, rising edge.
- reset_n, input, 1: asynchronous active-low reset.
- flush, input, 1: synchronous pipeline kill.
- in_valid, input, 1: upstream op valid.
- in_ready, output, 1: unit can accept an op this cycle.
- in_data, input, XLEN: rs1 operand.
- in_shamt, input, $clog2(XLEN): shift amount (rs2 or imm low bits).
- in_op, input, 2: shift_op_t; 00 SLL, 01 SRL, 11 SRA, 10 reserved.
- in_word, input, 1: *W variant.
- in_tag, input, TAG_W: passthrough tag.
- out_valid, output, 1: result valid.
- out_ready, input, 1: downstream accepts.
- out_data, output, XLEN: shift result.
- out_tag, output, TAG_W: tag of the result.
- busy, output, 1: any stage holds a valid op.

Behaviour:
- Reset (async, reset_n=0): s1_valid=0, s2_valid=0, out_valid=0, out_data=0, out_tag=0, busy=0. On release the unit is empty; in_ready=1 on the next cycle.
- Stage 1 (operand prep, registered on accept):
  - Word ops: shamt masked to 5 bits.
  - Word SRL: data = zero-extended in_data[31:0].
  - Word SRA: data = sign-extended in_data[31:0].
  - Word SLL: data unchanged.
  - Non-word ops: data and full shamt unchanged.
  - Reserved op 10 is decoded as SLL.
- Stage 2 (registered): barrel shifter output with left_or_right_shift = op[0] and arithmetic_right_shift = op[1]&op[0]. For word ops the result is sign-extended from bit 31.
- Handshake:
  - s2_adv = !s2_valid | out_ready.
  - s1_adv = !s1_valid | s2_adv.
  - in_ready = s1_adv & !flush.
  - The ready chain is combinational, giving full throughput of 1 op/cycle.
- Latency: exactly 2 cycles from accept (in_valid & in_ready at edge N) to out_valid at N+2, absent stalls.
- Stall: while out_valid & !out_ready, out_data and out_tag hold stable. Stage 1 fills, then in_ready deasserts. Ops are never dropped, duplicated, or reordered.
- Simultaneous out transfer and new accept with both stages full: both stages advance in the same cycle.
- Data registers load only when their stage advances. The valid bit clears when the stage drains with no new input.
- flush: on the next edge both valids clear and no input is accepted. flush overrides a concurrent in_valid. Data registers are not cleared.
- Reset mid-operation: in-flight ops are discarded immediately; no spurious out_valid afterwards.
- shamt = 0 returns the operand unchanged (word ops: sign-extended low 32 bits).
- busy = s1_valid | s2_valid.

Optional Feature:
- SHIFT_WORD_OPS_EN:
  - Defined: *W handling as above; legal only with XLEN=64.
  - Undefined: in_word is ignored, every op is full-width, and the stage-1 masking and stage-2 sign-extension logic is omitted.
  - Guard: defining it with XLEN=32 is a compile-time error via an elaboration check.

Decomposition:
- shift_pkg: shift_op_t enum (SLL=2'b00, SRL=2'b01, RSV=2'b10, SRA=2'b11) and the constant WORD_W=32.
- Sub-module: the existing full_barrel_shifter, instantiated once in stage 2 with XLEN passed through. No other sub-modules.

Test Plan:
- Basic latency: SLL, in_data=64'h1, shamt=63 -> out_data=64'h8000_0000_0000_0000 exactly 2 cycles after accept; tag preserved.
- SRA vs SRL: in_data=64'hF000_0000_0000_0000, shamt=4 -> SRA=64'hFF00_0000_0000_0000, SRL=64'h0F00_0000_0000_0000.
- Word ops (macro on), in_data=64'hDEAD_BEEF_8000_0000, shamt=4:
  - SRAW -> 64'hFFFF_FFFF_F800_0000.
  - SRLW -> 64'h0000_0000_0800_0000.
  - SLLW, in_data=1, shamt=31 -> 64'hFFFF_FFFF_8000_0000.
  - SLLW, shamt=33 -> 64'h2.
- Backpressure: 4 back-to-back ops (tags 1..4) with out_ready=0 for 5 cycles:
  - in_ready drops after 2 accepts.
  - out_data is stable throughout the stall.
  - After out_ready=1, results emerge in order 1,2,3,4 at 1 per cycle.
- Flush/reset: assert flush with 2 ops in flight and in_valid=1 -> no out_valid afterwards, busy=0 next cycle, input not accepted. Repeat with reset_n pulsed mid-stream -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the execute-stage shift unit.
package shift_pkg;

  // Shift micro-op encoding as delivered by decode.
  typedef enum logic [1:0] {
    SLL = 2'b00,
    SRL = 2'b01,
    RSV = 2'b10,
    SRA = 2'b11
  } shift_op_t;

  // Width of the *W (word) operand on RV64.
  localparam int unsigned WORD_W = 32;

endpackage

// File: rtl/full_barrel_shifter.sv
// Combinational logarithmic barrel shifter: left, logical right or arithmetic right.
module full_barrel_shifter #(
  parameter int unsigned XLEN = 64
) (
  input  logic [XLEN-1:0]         data_i,
  input  logic [$clog2(XLEN)-1:0] shamt_i,
  input  logic                    left_or_right_shift_i,  // 0: left, 1: right
  input  logic                    arithmetic_right_shift_i,
  output logic [XLEN-1:0]         result_o
);

  localparam int unsigned ShamtW = $clog2(XLEN);

  logic [XLEN-1:0] acc;
  logic            fill;

  // One conditional power-of-two shift per shamt bit; right shifts backfill with the sign.
  always_comb begin
    acc  = data_i;
    fill = arithmetic_right_shift_i & data_i[XLEN-1];
    for (int unsigned i = 0; i < ShamtW; i++) begin
      if (shamt_i[i]) begin
        if (!left_or_right_shift_i) begin
          acc = acc << (1 << i);
        end else begin
          acc = (acc >> (1 << i)) | (fill ? ~({XLEN{1'b1}} >> (1 << i)) : '0);
        end
      end
    end
    result_o = acc;
  end

endmodule

// File: rtl/shift_exec_unit.sv
// Execute-stage shift unit: operand prep (stage 1), barrel shift + word fixup (stage 2),
// elastic valid/ready pipeline with a combinational ready chain.
// Optional macro SHIFT_WORD_OPS_EN enables RV64 *W handling (requires XLEN == 64).
module shift_exec_unit
  import shift_pkg::*;
#(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned TAG_W = 5
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    flush,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [XLEN-1:0]         in_data,
  input  logic [$clog2(XLEN)-1:0] in_shamt,
  input  logic [1:0]              in_op,
  input  logic                    in_word,
  input  logic [TAG_W-1:0]        in_tag,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [XLEN-1:0]         out_data,
  output logic [TAG_W-1:0]        out_tag,
  output logic                    busy
);

  localparam int unsigned ShamtW = $clog2(XLEN);

`ifdef SHIFT_WORD_OPS_EN
  if (XLEN != 64) begin : g_xlen_chk
    $error("shift_exec_unit: SHIFT_WORD_OPS_EN requires XLEN == 64");
  end
`endif

  // Stage 1 state
  logic              s1_valid_q, s1_valid_d;
  logic [XLEN-1:0]   s1_data_q;
  logic [ShamtW-1:0] s1_shamt_q;
  shift_op_t         s1_op_q;
  logic [TAG_W-1:0]  s1_tag_q;
`ifdef SHIFT_WORD_OPS_EN
  logic              s1_word_q;
`endif

  // Stage 2 state
  logic              s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]   out_data_q;
  logic [TAG_W-1:0]  out_tag_q;

  logic              s1_adv, s2_adv, accept, s2_load;
  shift_op_t         op_dec;
  logic [XLEN-1:0]   prep_data;
  logic [ShamtW-1:0] prep_shamt;
  logic [XLEN-1:0]   shift_res;
  logic [XLEN-1:0]   res_fix;

  // Ready chain: a stage may take new data if empty or if it empties this cycle.
  always_comb begin
    s2_adv   = !s2_valid_q | out_ready;
    s1_adv   = !s1_valid_q | s2_adv;
    in_ready = s1_adv & !flush;
    accept   = in_valid & in_ready;
    s2_load  = s2_adv & s1_valid_q & !flush;
  end

  // Valid-bit next state; flush kills both stages regardless of traffic.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv) s1_valid_d = accept;
      if (s2_adv) s2_valid_d = s1_valid_q;
    end
  end

  // Operand prep: reserved op runs as SLL; word ops mask shamt and pre-extend rs1.
  always_comb begin
    op_dec     = (in_op == RSV) ? SLL : shift_op_t'(in_op);
    prep_data  = in_data;
    prep_shamt = in_shamt;
`ifdef SHIFT_WORD_OPS_EN
    if (in_word) begin
      prep_shamt      = '0;
      prep_shamt[4:0] = in_shamt[4:0];
      if (op_dec == SRL) begin
        prep_data = {{(XLEN - WORD_W){1'b0}}, in_data[WORD_W-1:0]};
      end else if (op_dec == SRA) begin
        prep_data = {{(XLEN - WORD_W){in_data[WORD_W-1]}}, in_data[WORD_W-1:0]};
      end
    end
`endif
  end

`ifndef SHIFT_WORD_OPS_EN
  // in_word has no effect when word ops are compiled out.
  logic unused_in_word;
  assign unused_in_word = in_word;
`endif

  // Stage 1 registers: valid tracks occupancy, payload loads only on accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s1_shamt_q <= '0;
      s1_op_q    <= SLL;
      s1_tag_q   <= '0;
`ifdef SHIFT_WORD_OPS_EN
      s1_word_q  <= 1'b0;
`endif
    end else begin
      s1_valid_q <= s1_valid_d;
      if (accept) begin
        s1_data_q  <= prep_data;
        s1_shamt_q <= prep_shamt;
        s1_op_q    <= op_dec;
        s1_tag_q   <= in_tag;
`ifdef SHIFT_WORD_OPS_EN
        s1_word_q  <= in_word;
`endif
      end
    end
  end

  full_barrel_shifter #(
    .XLEN (XLEN)
  ) u_shifter (
    .data_i                   (s1_data_q),
    .shamt_i                  (s1_shamt_q),
    .left_or_right_shift_i    (s1_op_q[0]),
    .arithmetic_right_shift_i (s1_op_q[1] & s1_op_q[0]),
    .result_o                 (shift_res)
  );

  // Word results are sign-extended from bit 31 after the shift.
  always_comb begin
    res_fix = shift_res;
`ifdef SHIFT_WORD_OPS_EN
    if (s1_word_q) begin
      res_fix = {{(XLEN - WORD_W){shift_res[WORD_W-1]}}, shift_res[WORD_W-1:0]};
    end
`endif
  end

  // Stage 2 registers: result holds while downstream stalls.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s2_valid_q <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
    end else begin
      s2_valid_q <= s2_valid_d;
      if (s2_load) begin
        out_data_q <= res_fix;
        out_tag_q  <= s1_tag_q;
      end
    end
  end

  // Output drive
  always_comb begin
    out_valid = s2_valid_q;
    out_data  = out_data_q;
    out_tag   = out_tag_q;
    busy      = s1_valid_q | s2_valid_q;
  end

endmodule

// File: tb/tb_shift_exec_unit.sv
// Scoreboard bench for shift_exec_unit: driver pushes expected results, monitor pops on transfer.
module tb_shift_exec_unit;

  logic        clock = 1'b0;
  logic        reset_n, flush, in_valid, in_ready, in_word, out_valid, out_ready, busy;
  logic [63:0] in_data, out_data;
  logic [5:0]  in_shamt;
  logic [1:0]  in_op;
  logic [4:0]  in_tag, out_tag;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  tag;
    bit          lat;
    int          acc_cyc;
  } exp_t;

  exp_t sb[$];
  int   pop_cyc[$];
  int   cyc = 0;
  int   n_chk = 0;
  int   n_fail = 0;
  bit   presented = 1'b0;

  shift_exec_unit #(
    .XLEN  (64),
    .TAG_W (5)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .in_word   (in_word),
    .in_tag    (in_tag),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag),
    .busy      (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Monitor: every presented result is compared against the oldest expectation.
  always @(negedge clock) begin
    if (reset_n && out_valid) begin
      if (sb.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_out_valid: got tag %0d data %h, expected nothing", out_tag,
                 out_data);
      end else begin
        check("sb_data", out_data, sb[0].data);
        check("sb_tag", {59'd0, out_tag}, {59'd0, sb[0].tag});
        if (!presented && sb[0].lat) begin
          check("latency", 64'(cyc), 64'(sb[0].acc_cyc + 2));
        end
        presented = 1'b1;
        if (out_ready) begin
          void'(sb.pop_front());
          pop_cyc.push_back(cyc);
          presented = 1'b0;
        end
      end
    end
  end

  // Drive one op starting in the posedge+1 phase; returns in the posedge+1 phase after accept.
  task automatic send(input logic [63:0] d, input logic [5:0] sh, input logic [1:0] op,
                      input logic w, input logic [4:0] tag, input logic [63:0] exp_d,
                      input bit lat, input bit push);
    exp_t e;
    bit   ok;
    in_valid = 1'b1;
    in_data  = d;
    in_shamt = sh;
    in_op    = op;
    in_word  = w;
    in_tag   = tag;
    ok       = 1'b0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clock);
      if (in_ready) begin
        ok = 1'b1;
        if (push) begin
          e.data = exp_d; e.tag = tag; e.lat = lat; e.acc_cyc = cyc;
          sb.push_back(e);
        end
      end
      @(posedge clock);
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: tag %0d got no in_ready, expected accept", tag);
    end
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 100) begin
      @(posedge clock);
      k++;
    end
    check(name, 64'(sb.size()), 64'd0);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_data = '0; in_shamt = '0; in_op = 2'b00; in_word = 1'b0; in_tag = '0;
    #12;
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_out_data", out_data, 64'd0);
    check("rst_out_tag", {59'd0, out_tag}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    @(posedge clock); #1;

    // Full-width directed vectors
    send(64'h1, 6'd63, 2'b00, 1'b0, 5'd7, 64'h8000_0000_0000_0000, 1'b1, 1'b1);
    drain("drain_basic");
    send(64'hF000_0000_0000_0000, 6'd4, 2'b11, 1'b0, 5'd1, 64'hFF00_0000_0000_0000, 1'b1, 1'b1);
    send(64'hF000_0000_0000_0000, 6'd4, 2'b01, 1'b0, 5'd2, 64'h0F00_0000_0000_0000, 1'b1, 1'b1);
    send(64'h1234, 6'd0, 2'b11, 1'b0, 5'd3, 64'h1234, 1'b1, 1'b1);
    send(64'h3, 6'd4, 2'b10, 1'b0, 5'd4, 64'h30, 1'b1, 1'b1);
`ifdef SHIFT_WORD_OPS_EN
    send(64'hDEAD_BEEF_8000_0000, 6'd4, 2'b11, 1'b1, 5'd5, 64'hFFFF_FFFF_F800_0000, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_8000_0000, 6'd4, 2'b01, 1'b1, 5'd6, 64'h0000_0000_0800_0000, 1'b1, 1'b1);
    send(64'h1, 6'd31, 2'b00, 1'b1, 5'd8, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1);
    send(64'h1, 6'd33, 2'b00, 1'b1, 5'd9, 64'h2, 1'b1, 1'b1);
    send(64'hDEAD_BEEF_8000_0000, 6'd0, 2'b01, 1'b1, 5'd10, 64'hFFFF_FFFF_8000_0000, 1'b1, 1'b1);
`else
    // in_word is ignored: full-width results
    send(64'hF000_0000_0000_0000, 6'd4, 2'b11, 1'b1, 5'd5, 64'hFF00_0000_0000_0000, 1'b1, 1'b1);
    send(64'h1, 6'd33, 2'b00, 1'b1, 5'd9, 64'h2_0000_0000, 1'b1, 1'b1);
`endif
    drain("drain_vectors");

    // Backpressure: 4 ops back-to-back with a 5-cycle stall
    out_ready = 1'b0;
    pop_cyc.delete();
    fork
      begin
        send(64'h1, 6'd1, 2'b00, 1'b0, 5'd1, 64'h2, 1'b0, 1'b1);
        send(64'h1, 6'd2, 2'b00, 1'b0, 5'd2, 64'h4, 1'b0, 1'b1);
        send(64'h1, 6'd3, 2'b00, 1'b0, 5'd3, 64'h8, 1'b0, 1'b1);
        send(64'h1, 6'd4, 2'b00, 1'b0, 5'd4, 64'h10, 1'b0, 1'b1);
      end
      begin
        repeat (4) @(negedge clock);
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        check("bp_queued", 64'(sb.size()), 64'd2);
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    drain("drain_bp");
    check("bp_pop_count", 64'(pop_cyc.size()), 64'd4);
    if (pop_cyc.size() == 4) begin
      for (int i = 1; i < 4; i++) check("bp_rate", 64'(pop_cyc[i] - pop_cyc[i-1]), 64'd1);
    end

    // Flush with 2 ops in flight and a concurrent in_valid
    out_ready = 1'b0;
    send(64'h5, 6'd1, 2'b00, 1'b0, 5'd11, 64'hA, 1'b0, 1'b1);
    send(64'h5, 6'd2, 2'b00, 1'b0, 5'd12, 64'h14, 1'b0, 1'b1);
    flush = 1'b1;
    in_valid = 1'b1; in_tag = 5'd13;
    @(negedge clock);
    check("flush_in_ready", {63'd0, in_ready}, 64'd0);
    @(posedge clock); #1;
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    sb.delete();
    presented = 1'b0;
    @(negedge clock);
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_out_valid", {63'd0, out_valid}, 64'd0);
    repeat (4) @(negedge clock);
    check("flush_busy_later", {63'd0, busy}, 64'd0);
    @(posedge clock); #1;

    // Reset pulsed mid-stream
    out_ready = 1'b0;
    send(64'h7, 6'd1, 2'b00, 1'b0, 5'd14, 64'hE, 1'b0, 1'b1);
    send(64'h7, 6'd2, 2'b00, 1'b0, 5'd15, 64'h1C, 1'b0, 1'b1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_mid_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_mid_out_data", out_data, 64'd0);
    check("rst_mid_out_tag", {59'd0, out_tag}, 64'd0);
    check("rst_mid_busy", {63'd0, busy}, 64'd0);
    sb.delete();
    presented = 1'b0;
    @(posedge clock); #1;
    reset_n = 1'b1; out_ready = 1'b1;
    repeat (3) @(negedge clock);
    check("post_rst_busy", {63'd0, busy}, 64'd0);
    @(posedge clock); #1;
    send(64'h8000_0000_0000_0000, 6'd63, 2'b11, 1'b0, 5'd16, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
         1'b1);
    drain("drain_post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
